prng_stream: RTL

- Parametrised pseudo-random word generator with a seed-load port and a valid/ready output stream.
- Supports two generator modes: 3-shift xorshift and Galois LFSR.
- Includes a DEPTH-entry prefetch FIFO, so a consumer can pop one word per cycle without stalling the generator.
- Sits between the top-level pins/host interface and any consumer needing a random word stream. It is the multi-width, back-pressured generation of the team's 8-bit xorshift generator.

---
 rtl/prng_pkg.sv | 12 +
 rtl/prng_fifo.sv | 39 +++
 rtl/prng_stream.sv | 75 +++++++
 3 files changed

// File: rtl/prng_pkg.sv
// prng_pkg: shared mode encodings, FSM states and default Galois tap masks for prng_stream.
package prng_pkg;
  localparam logic MODE_XORSHIFT = 1'b0;
  localparam logic MODE_LFSR = 1'b1;
  typedef enum logic {UNSEEDED, RUN} fsm_t;
  localparam logic [31:0] TAPS_8 = 32'h0000_00B8;
  localparam logic [31:0] TAPS_16 = 32'h0000_B400;
  localparam logic [31:0] TAPS_32 = 32'h8020_0003;
  function automatic logic [31:0] default_taps(input int width);
    return width >= 32 ? TAPS_32 : width >= 16 ? TAPS_16 : TAPS_8;
  endfunction
endpackage

// File: rtl/prng_fifo.sv
// prng_fifo: WIDTH x DEPTH synchronous FIFO with flush; head reads as zero when empty.
module prng_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count;
  logic push_ok, pop_ok;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign pop_ok = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end
  always_ff @(posedge clk)
    if (push_ok) mem[wr_ptr] <= push_data;
endmodule

// File: rtl/prng_stream.sv
// prng_stream: seedable xorshift / Galois LFSR word generator feeding a prefetch FIFO
// with a valid/ready output stream; a seed load flushes the FIFO and restarts the sequence.
module prng_stream
  import prng_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned SHIFT_A = 3,
  parameter int unsigned SHIFT_B = 5,
  parameter int unsigned SHIFT_C = 4,
  parameter logic [31:0] LFSR_TAPS = default_taps(WIDTH),
  parameter logic [WIDTH-1:0] SEED_DEFAULT = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             seed_valid,
  input  logic [WIDTH-1:0] seed_data,
  input  logic             seed_mode,
  output logic             seed_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             seeded
);
  localparam logic [WIDTH-1:0] TAPS = WIDTH'(LFSR_TAPS);
  if (SHIFT_A >= WIDTH || SHIFT_B >= WIDTH || SHIFT_C >= WIDTH) begin : g_bad_shift
    $error("prng_stream: xorshift shifts must be less than WIDTH");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("prng_stream: DEPTH must be a power of two, at least 2");
  end
  function automatic logic [WIDTH-1:0] next_word(input logic [WIDTH-1:0] s, input logic m);
    logic [WIDTH-1:0] t1, t2;
    t1 = s ^ (s << SHIFT_A);
    t2 = t1 ^ (t1 >> SHIFT_B);
    return m == MODE_LFSR ? (s >> 1) ^ (s[0] ? TAPS : '0) : t2 ^ (t2 << SHIFT_C);
  endfunction
  fsm_t fsm, fsm_nxt;
  logic [WIDTH-1:0] state, nxt;
  logic mode, full, empty, pop, gen;
  assign nxt = next_word(state, mode);
  assign seed_ready = 1'b1;
  assign seeded = fsm == RUN;
  assign out_valid = fsm == RUN && !empty;
  // Seed wins over pop and generate; the FIFO is flushed on the same edge.
  assign pop = out_valid && out_ready && !seed_valid;
  assign gen = fsm == RUN && enable && !seed_valid && (!full || pop);
  always_ff @(posedge clk)
    fsm <= !rst_n ? UNSEEDED : fsm_nxt;
  always_comb
    fsm_nxt = seed_valid ? RUN : fsm;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= '0;
      mode <= MODE_XORSHIFT;
    end else if (seed_valid) begin
      state <= seed_data == '0 ? SEED_DEFAULT : seed_data;
      mode <= seed_mode;
    end else if (gen) begin
      state <= nxt;
    end
  end
  prng_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .flush(seed_valid),
    .push(gen),
    .push_data(nxt),
    .pop(pop),
    .full(full),
    .empty(empty),
    .head(out_data)
  );
endmodule
